// File: rtl/peg_l2_mac_tx_framer.sv
// MAC TX framer: forwards L2 bytes, zero-pads runt frames,
// feeds the FCS generator, appends the FCS and inserts the IFG.
module peg_l2_mac_tx_framer #(
  parameter int MIN_FRAME_BYTES = 60,
  parameter bit PAD_EN          = 1'b1,
  parameter int IFG_BYTES       = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        in_sop,
  input  logic        in_eop,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic        out_sop,
  output logic        out_eop,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        fcs_calc_rst,
  output logic        fcs_calc_valid,
  output logic [7:0]  fcs_calc_data,
  input  logic [31:0] fcs,
  output logic        err_nosop
);

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PAD,
    FCS,
    IFG
  } state_t;

  localparam logic [10:0] MIN_CNT  = 11'(MIN_FRAME_BYTES);
  localparam logic [10:0] CNT_MAX  = 11'h7FF;
  localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES - 1);

  state_t      state;
  state_t      state_nxt;
  state_t      eop_state;
  logic [10:0] byte_cnt;
  logic [10:0] byte_cnt_nxt;
  logic [10:0] cnt_inc;
  logic [1:0]  fcs_idx;
  logic [1:0]  fcs_idx_nxt;
  logic [7:0]  ifg_cnt;
  logic [7:0]  ifg_cnt_nxt;
  logic        init_pend;
  logic        sop_hit;

  assign sop_hit = in_valid & in_sop;

  // Saturating count of data+pad bytes including the current one.
  assign cnt_inc = (byte_cnt == CNT_MAX) ? byte_cnt
                                         : byte_cnt + 11'd1;

  // Where the frame goes after its last input byte is accepted.
  assign eop_state = (PAD_EN && (cnt_inc < MIN_CNT)) ? PAD : FCS;

  // State and counter registers; reset also schedules a CRC re-init.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      byte_cnt  <= '0;
      fcs_idx   <= '0;
      ifg_cnt   <= '0;
      init_pend <= 1'b1;
    end else begin
      state     <= state_nxt;
      byte_cnt  <= byte_cnt_nxt;
      fcs_idx   <= fcs_idx_nxt;
      ifg_cnt   <= ifg_cnt_nxt;
      init_pend <= 1'b0;
    end
  end

  // Next-state, counter updates and all handshake/datapath outputs.
  always_comb begin
    state_nxt      = state;
    byte_cnt_nxt   = byte_cnt;
    fcs_idx_nxt    = fcs_idx;
    ifg_cnt_nxt    = ifg_cnt;
    in_ready       = 1'b0;
    out_valid      = 1'b0;
    out_sop        = 1'b0;
    out_eop        = 1'b0;
    out_data       = 8'h00;
    fcs_calc_rst   = 1'b0;
    fcs_calc_valid = 1'b0;
    fcs_calc_data  = 8'h00;
    err_nosop      = 1'b0;

    unique case (state)
      IDLE: begin
        // A sop byte is only taken when the sink can take it too,
        // so a stalled sink never loses the first byte.
        in_ready  = ~sop_hit | out_ready;
        out_valid = sop_hit;
        out_sop   = sop_hit;
        out_data  = sop_hit ? in_data : 8'h00;
        err_nosop = in_valid & ~in_sop;
        if (sop_hit && out_ready) begin
          fcs_calc_valid = 1'b1;
          fcs_calc_data  = in_data;
          byte_cnt_nxt   = cnt_inc;
          state_nxt      = in_eop ? eop_state : DATA;
        end
      end

      DATA: begin
        in_ready  = out_ready;
        out_valid = in_valid;
        out_data  = in_data;
        if (in_valid && out_ready) begin
          fcs_calc_valid = 1'b1;
          fcs_calc_data  = in_data;
          byte_cnt_nxt   = cnt_inc;
          if (in_eop) begin
            state_nxt = eop_state;
          end
        end
      end

      PAD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          fcs_calc_valid = 1'b1;
          byte_cnt_nxt   = cnt_inc;
          if (cnt_inc >= MIN_CNT) begin
            state_nxt = FCS;
          end
        end
      end

      FCS: begin
        out_valid = 1'b1;
        out_data  = fcs[{fcs_idx, 3'b000} +: 8];
        out_eop   = (fcs_idx == 2'd3);
        if (out_ready) begin
          if (fcs_idx == 2'd3) begin
            fcs_calc_rst = 1'b1;
            fcs_idx_nxt  = 2'd0;
            byte_cnt_nxt = '0;
            ifg_cnt_nxt  = '0;
            state_nxt    = IFG;
          end else begin
            fcs_idx_nxt = fcs_idx + 2'd1;
          end
        end
      end

      IFG: begin
        if (ifg_cnt == IFG_LAST) begin
          ifg_cnt_nxt = '0;
          state_nxt   = IDLE;
        end else begin
          ifg_cnt_nxt = ifg_cnt + 8'd1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // First cycle out of reset restarts the CRC, abandoning any
    // partial frame that was in flight.
    if (init_pend && !rst) begin
      fcs_calc_rst = 1'b1;
    end
  end

endmodule

// File: tb/tb_peg_l2_mac_tx_framer.sv
// Directed bench for peg_l2_mac_tx_framer with a behavioural
// CRC-32 FCS generator. Instance a: PAD_EN=0, instance b: PAD_EN=1.
`timescale 1ns/1ps
module tb_peg_l2_mac_tx_framer;

  localparam int MIN_B = 60;
  localparam int IFG_B = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic in_sop = 1'b0;
  logic in_eop = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic out_ready;
  logic stall_en = 1'b0;

  logic in_ready_a, out_valid_a, out_sop_a, out_eop_a;
  logic [7:0] out_data_a, calc_data_a;
  logic calc_rst_a, calc_valid_a, err_a;
  logic [31:0] fcs_a, crc_a;

  logic in_ready_b, out_valid_b, out_sop_b, out_eop_b;
  logic [7:0] out_data_b, calc_data_b;
  logic calc_rst_b, calc_valid_b, err_b;
  logic [31:0] fcs_b, crc_b;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] tx_buf [0:127];
  logic [7:0] exp_buf [0:255];
  int exp_len;
  logic [31:0] ref_crc = 32'hCBF43926;

  int qa[$];
  int qb[$];
  int eop_a = 0;
  int eop_b = 0;
  int crst_b = 0;
  int stab_a = 0;
  int gap_b = -1;

  peg_l2_mac_tx_framer #(
    .MIN_FRAME_BYTES(MIN_B), .PAD_EN(1'b0), .IFG_BYTES(IFG_B)
  ) u_dut_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_data(in_data), .in_ready(in_ready_a),
    .out_valid(out_valid_a), .out_sop(out_sop_a),
    .out_eop(out_eop_a), .out_data(out_data_a),
    .out_ready(out_ready),
    .fcs_calc_rst(calc_rst_a), .fcs_calc_valid(calc_valid_a),
    .fcs_calc_data(calc_data_a), .fcs(fcs_a),
    .err_nosop(err_a)
  );

  peg_l2_mac_tx_framer #(
    .MIN_FRAME_BYTES(MIN_B), .PAD_EN(1'b1), .IFG_BYTES(IFG_B)
  ) u_dut_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_data(in_data), .in_ready(in_ready_b),
    .out_valid(out_valid_b), .out_sop(out_sop_b),
    .out_eop(out_eop_b), .out_data(out_data_b),
    .out_ready(out_ready),
    .fcs_calc_rst(calc_rst_b), .fcs_calc_valid(calc_valid_b),
    .fcs_calc_data(calc_data_b), .fcs(fcs_b),
    .err_nosop(err_b)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] crc_upd(input logic [31:0] c,
                                          input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int k = 0; k < 8; k++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Behavioural FCS generators: reflected CRC-32, registered output.
  always_ff @(posedge clk) begin
    if (calc_rst_a) crc_a <= 32'hFFFFFFFF;
    else if (calc_valid_a) crc_a <= crc_upd(crc_a, calc_data_a);
  end
  always_ff @(posedge clk) begin
    if (calc_rst_b) crc_b <= 32'hFFFFFFFF;
    else if (calc_valid_b) crc_b <= crc_upd(crc_b, calc_data_b);
  end
  assign fcs_a = ~crc_a;
  assign fcs_b = ~crc_b;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      out_ready <= stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor a: captured bytes, eop count, stall stability.
  initial begin
    logic held;
    logic [10:0] hold;
    held = 1'b0;
    hold = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (held && {out_valid_a, out_sop_a, out_eop_a, out_data_a} !== hold)
          stab_a++;
        held = out_valid_a & ~out_ready;
        hold = {out_valid_a, out_sop_a, out_eop_a, out_data_a};
        if (out_valid_a && out_ready) begin
          qa.push_back(int'({out_sop_a, out_eop_a, out_data_a}));
          if (out_eop_a) eop_a++;
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  // Monitor b: captured bytes, eop count, calc_rst pulses, IFG gap.
  initial begin
    bit meas;
    int gcnt;
    meas = 1'b0;
    gcnt = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (meas) begin
          if (!in_ready_b) gcnt++;
          else begin
            gap_b = gcnt;
            meas = 1'b0;
          end
        end
        if (calc_rst_b) crst_b++;
        if (out_valid_b && out_ready) begin
          qb.push_back(int'({out_sop_b, out_eop_b, out_data_b}));
          if (out_eop_b) begin
            eop_b++;
            meas = 1'b1;
            gcnt = 0;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    in_sop = 1'b0;
    in_eop = 1'b0;
    in_data = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_frame(input bit sel, input int n, input bit keep);
    for (int i = 0; i < n; i++) begin
      int wc;
      bit rdy;
      wc = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_sop = (i == 0);
      in_eop = (i == n - 1);
      in_data = tx_buf[i];
      forever begin
        #1;
        rdy = sel ? in_ready_b : in_ready_a;
        if (rdy) break;
        wc++;
        if (wc > 2000) begin
          n_chk++;
          n_fail++;
          $display("FAIL send_timeout byte %0d: in_ready got 0, need 1", i);
          in_valid = 1'b0;
          return;
        end
        @(negedge clk);
      end
    end
    if (!keep) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_sop = 1'b0;
      in_eop = 1'b0;
    end
  endtask

  task automatic wait_eop(input bit sel, input int target);
    int c;
    c = 0;
    while ((sel ? eop_b : eop_a) < target) begin
      @(negedge clk);
      #2;
      c++;
      if (c > 3000) begin
        n_chk++;
        n_fail++;
        $display("FAIL eop_timeout: eop count got %0d, need %0d",
                 sel ? eop_b : eop_a, target);
        return;
      end
    end
  endtask

  task automatic build_exp(input int n, input bit pad);
    int len;
    logic [31:0] c;
    len = (pad && n < MIN_B) ? MIN_B : n;
    for (int i = 0; i < len; i++)
      exp_buf[i] = (i < n) ? tx_buf[i] : 8'h00;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < len; i++) c = crc_upd(c, exp_buf[i]);
    c = ~c;
    for (int k = 0; k < 4; k++) exp_buf[len + k] = c[8*k +: 8];
    exp_len = len + 4;
  endtask

  task automatic load_digits();
    for (int i = 0; i < 9; i++) tx_buf[i] = 8'(49 + i);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_chk++;
    if ({in_ready_a, out_valid_a, out_sop_a, out_eop_a, out_data_a,
         calc_rst_a, calc_valid_a, calc_data_a, err_a} !== 23'h400000) begin
      n_fail++;
      $display("FAIL reset_outputs_a: got %h, need 400000",
               {in_ready_a, out_valid_a, out_sop_a, out_eop_a, out_data_a,
                calc_rst_a, calc_valid_a, calc_data_a, err_a});
    end
    n_chk++;
    if ({in_ready_b, out_valid_b, out_sop_b, out_eop_b, out_data_b,
         calc_rst_b, calc_valid_b, calc_data_b, err_b} !== 23'h400000) begin
      n_fail++;
      $display("FAIL reset_outputs_b: got %h, need 400000",
               {in_ready_b, out_valid_b, out_sop_b, out_eop_b, out_data_b,
                calc_rst_b, calc_valid_b, calc_data_b, err_b});
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_chk++;
    if (calc_rst_b !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_calc_rst: got %b, need 1", calc_rst_b);
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (calc_rst_b !== 1'b0) begin
      n_fail++;
      $display("FAIL calc_rst_one_cycle: got %b, need 0", calc_rst_b);
    end
  endtask

  task automatic test_nopad_digits();
    int s;
    do_reset();
    qa.delete();
    load_digits();
    s = eop_a;
    send_frame(1'b0, 9, 1'b0);
    wait_eop(1'b0, s + 1);
    n_chk++;
    if (qa.size() !== 13) begin
      n_fail++;
      $display("FAIL digits_len: got %0d, need 13", qa.size());
    end
    for (int i = 0; i < 13; i++) begin
      int e, g;
      logic [7:0] d;
      d = (i < 9) ? 8'(49 + i) : ref_crc[8*(i-9) +: 8];
      e = {22'd0, (i == 0), (i == 12), d};
      g = (i < qa.size()) ? qa[i] : -1;
      n_chk++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL digits_byte%0d: got %h, need %h", i, g, e);
      end
    end
  endtask

  task automatic test_pad_boundary();
    int s;
    do_reset();
    for (int n = 60; n <= 61; n++) begin
      qb.delete();
      for (int i = 0; i < n; i++) tx_buf[i] = 8'(i * 13 + 5);
      build_exp(n, 1'b1);
      s = eop_b;
      send_frame(1'b1, n, 1'b0);
      wait_eop(1'b1, s + 1);
      n_chk++;
      if (qb.size() !== n + 4) begin
        n_fail++;
        $display("FAIL len_%0dB: got %0d, need %0d", n, qb.size(), n + 4);
      end
      for (int i = 0; i < exp_len; i++) begin
        int e, g;
        e = {22'd0, (i == 0), (i == exp_len - 1), exp_buf[i]};
        g = (i < qb.size()) ? qb[i] : -1;
        n_chk++;
        if (g !== e) begin
          n_fail++;
          $display("FAIL frame%0dB_byte%0d: got %h, need %h", n, i, g, e);
        end
      end
    end
  endtask

  task automatic test_one_byte_pad();
    int s;
    do_reset();
    qb.delete();
    tx_buf[0] = 8'hAA;
    build_exp(1, 1'b1);
    s = eop_b;
    send_frame(1'b1, 1, 1'b0);
    wait_eop(1'b1, s + 1);
    n_chk++;
    if (qb.size() !== 64) begin
      n_fail++;
      $display("FAIL one_byte_len: got %0d, need 64", qb.size());
    end
    for (int i = 0; i < exp_len; i++) begin
      int e, g;
      e = {22'd0, (i == 0), (i == 63), exp_buf[i]};
      g = (i < qb.size()) ? qb[i] : -1;
      n_chk++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL one_byte_byte%0d: got %h, need %h", i, g, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    int s, base;
    do_reset();
    @(negedge clk);
    #2;
    base = crst_b;
    gap_b = -1;
    qb.delete();
    for (int i = 0; i < 8; i++) tx_buf[i] = 8'(8'hC0 + i);
    s = eop_b;
    send_frame(1'b1, 8, 1'b1);
    send_frame(1'b1, 8, 1'b0);
    wait_eop(1'b1, s + 2);
    n_chk++;
    if (gap_b !== IFG_B) begin
      n_fail++;
      $display("FAIL ifg_gap: got %0d, need %0d", gap_b, IFG_B);
    end
    n_chk++;
    if (crst_b - base !== 2) begin
      n_fail++;
      $display("FAIL calc_rst_pulses: got %0d, need 2", crst_b - base);
    end
    n_chk++;
    if (qb.size() !== 128) begin
      n_fail++;
      $display("FAIL b2b_len: got %0d, need 128", qb.size());
    end
    n_chk++;
    if (((qb.size() > 64) ? qb[64] : -1) !== 32'h2C0) begin
      n_fail++;
      $display("FAIL b2b_second_sop: got %h, need 2c0",
               (qb.size() > 64) ? qb[64] : -1);
    end
  endtask

  task automatic test_stall();
    int s;
    do_reset();
    qa.delete();
    stab_a = 0;
    load_digits();
    stall_en = 1'b1;
    s = eop_a;
    send_frame(1'b0, 9, 1'b0);
    wait_eop(1'b0, s + 1);
    stall_en = 1'b0;
    n_chk++;
    if (stab_a !== 0) begin
      n_fail++;
      $display("FAIL stall_stability: got %0d changes, need 0", stab_a);
    end
    n_chk++;
    if (qa.size() !== 13) begin
      n_fail++;
      $display("FAIL stall_len: got %0d, need 13", qa.size());
    end
    for (int i = 0; i < 13; i++) begin
      int e, g;
      logic [7:0] d;
      d = (i < 9) ? 8'(49 + i) : ref_crc[8*(i-9) +: 8];
      e = {22'd0, (i == 0), (i == 12), d};
      g = (i < qa.size()) ? qa[i] : -1;
      n_chk++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL stall_byte%0d: got %h, need %h", i, g, e);
      end
    end
  endtask

  task automatic test_nosop_and_rst();
    int s;
    do_reset();
    qb.delete();
    @(negedge clk);
    in_valid = 1'b1;
    in_sop = 1'b0;
    in_data = 8'h55;
    #1;
    n_chk++;
    if ({err_b, out_valid_b} !== 2'b10) begin
      n_fail++;
      $display("FAIL nosop_pulse: got err/valid %b%b, need 10",
               err_b, out_valid_b);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_chk++;
    if (err_b !== 1'b0) begin
      n_fail++;
      $display("FAIL nosop_one_cycle: got %b, need 0", err_b);
    end
    repeat (3) @(negedge clk);
    n_chk++;
    if (qb.size() !== 0) begin
      n_fail++;
      $display("FAIL nosop_no_output: got %0d bytes, need 0", qb.size());
    end
    qa.delete();
    s = eop_a;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_sop = (i == 0);
      in_eop = 1'b0;
      in_data = 8'(8'h70 + i);
      if (i == 4) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    in_sop = 1'b0;
    #1;
    n_chk++;
    if ({calc_rst_a, out_valid_a} !== 2'b10) begin
      n_fail++;
      $display("FAIL midframe_rst: got calc_rst/valid %b%b, need 10",
               calc_rst_a, out_valid_a);
    end
    n_chk++;
    if (qa.size() !== 4 || eop_a !== s) begin
      n_fail++;
      $display("FAIL partial_frame: got %0d bytes eops %0d, need 4 and %0d",
               qa.size(), eop_a, s);
    end
    qa.delete();
    load_digits();
    s = eop_a;
    send_frame(1'b0, 9, 1'b0);
    wait_eop(1'b0, s + 1);
    for (int k = 0; k < 4; k++) begin
      int e, g;
      e = {22'd0, 1'b0, (k == 3), ref_crc[8*k +: 8]};
      g = (qa.size() > 9 + k) ? qa[9 + k] : -1;
      n_chk++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL after_rst_fcs%0d: got %h, need %h", k, g, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nopad_digits();
    test_pad_boundary();
    test_one_byte_pad();
    test_back_to_back();
    test_stall();
    test_nosop_and_rst();
    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
